shift_right_unit: RTL and testbench

Iterative right shifter for the CPU's execute stage. It implements SRL/SRA (and their variable forms) one bit position per clock, as the right-shift counterpart to the combinational left-shift logic in the datapath. It accepts a 32-bit operand and a 5-bit shift amount through a start/done handshake. The result is held stable until the next operation completes, so the control unit stalls the pipeline on `Busy` and writes back on `Done`.

---
 rtl/shift_right_unit.sv | 117 +++++++++++
 tb/tb_shift_right_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/shift_right_unit.sv
`default_nettype none
// ============================================================================
//  Module   : shift_right_unit
//  Purpose  : Iterative SRL/SRA unit that shifts one bit position per clock.
//             It uses a start/done handshake and holds the result in Out
//             until the next operation completes.
//  Revision : 1.0  initial release
// ============================================================================
//  Bit numbering: vectors are [WIDTH-1:0] and the MSB (sign bit) is bit
//  WIDTH-1. The numeric value on each bus is the one the pipeline expects,
//  so In = 0x80000000 means the sign bit is set.
// ============================================================================
module shift_right_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             Arith,
  input  logic [WIDTH-1:0] In,
  input  logic [SHW-1:0]   Shamt,
  output logic [WIDTH-1:0] Out,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [SHW-1:0] C_CNT_ONE = SHW'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q,  sreg_d;
  logic [SHW-1:0]   cnt_q,   cnt_d;
  logic             fill_q,  fill_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [WIDTH-1:0] shifted_w;

  // One-position right shift of the working value, inserting the fill bit at the MSB.
  always_comb begin
    shifted_w = {fill_q, sreg_q[WIDTH-1:1]};
  end

  // Next-state logic. Out is loaded only on the cycle that enters DONE.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          sreg_d = In;
          cnt_d  = Shamt;
          fill_d = Arith & In[WIDTH-1];
          if (Shamt == '0) begin
            // A zero-distance shift completes at once with the operand unchanged.
            state_d = S_DONE;
            out_d   = In;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        // Start is deliberately ignored here: there is no queueing.
        sreg_d = shifted_w;
        cnt_d  = cnt_q - C_CNT_ONE;
        if (cnt_q == C_CNT_ONE) begin
          state_d = S_DONE;
          out_d   = shifted_w;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  // State and output registers. The asynchronous reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Out  = out_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_right_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_right_unit
//  Purpose  : Self-checking bench for shift_right_unit. Results come from
//             plain >> and >>> arithmetic. Latency is derived from the shift
//             amount.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_right_unit;

  logic        clk;
  logic        rst;
  logic        Start;
  logic        Arith;
  logic [31:0] In;
  logic [4:0]  Shamt;
  logic [31:0] Out;
  logic        Busy;
  logic        Done;

  int          total;
  int          bad;
  logic [31:0] out_model;

  shift_right_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .Start (Start),
    .Arith (Arith),
    .In    (In),
    .Shamt (Shamt),
    .Out   (Out),
    .Busy  (Busy),
    .Done  (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int sh, input bit ar);
    logic signed [31:0] s;
    s = a;
    if (ar) return 32'(s >>> sh);
    return a >> sh;
  endfunction

  // Called at a negedge. Launches one operation and follows it until Done.
  // poke_at > 0 pulses a spurious Start with junk operands at that busy cycle.
  // chain = 1 returns on the Done cycle so the caller can start back-to-back.
  task automatic run_op(input string tag, input logic [31:0] a, input int sh,
                        input bit ar, input int poke_at, input bit chain);
    logic [31:0] exp;
    int          busy_n;
    int          done_at;
    exp     = ref_shift(a, sh, ar);
    In      = a;
    Shamt   = 5'(sh);
    Arith   = ar;
    Start   = 1'b1;
    @(negedge clk);
    Start   = 1'b0;
    In      = $urandom;
    Shamt   = 5'($urandom);
    Arith   = 1'($urandom);
    busy_n  = 0;
    done_at = 0;
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      check({tag, " busy&done"}, 32'(Busy & Done), 32'd0);
      if (Busy) busy_n++;
      if (Done) begin
        done_at = c;
      end else begin
        check({tag, " out hold"}, Out, out_model);
        if (c == poke_at) begin
          Start = 1'b1;
          In    = ~a;
        end
        @(negedge clk);
        Start = 1'b0;
      end
    end
    check({tag, " latency"}, 32'(done_at), 32'(sh + 1));
    check({tag, " busy cycles"}, 32'(busy_n), 32'(sh));
    check({tag, " result"}, Out, exp);
    out_model = exp;
    if (!chain) begin
      @(negedge clk);
      check({tag, " done pulse len"}, 32'(Done), 32'd0);
      check({tag, " idle busy"}, 32'(Busy), 32'd0);
      check({tag, " out kept"}, Out, out_model);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    out_model = 32'h0;
    rst       = 1'b1;
    Start     = 1'b0;
    Arith     = 1'b0;
    In        = 32'h0;
    Shamt     = 5'd0;
    repeat (3) @(negedge clk);
    check("reset out",  Out, 32'h0);
    check("reset busy", 32'(Busy), 32'd0);
    check("reset done", 32'(Done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("sra4",   32'h80000000, 4, 1'b1, 0, 1'b0);
    check("sra4 value", out_model, 32'hF8000000);
    run_op("srl4",   32'h80000000, 4, 1'b0, 0, 1'b0);
    check("srl4 value", out_model, 32'h08000000);
    run_op("sh0",    32'h12345678, 0, 1'b1, 0, 1'b0);
    run_op("sra31",  32'h80000000, 31, 1'b1, 0, 1'b0);
    check("sra31 value", out_model, 32'hFFFFFFFF);
    run_op("srl31",  32'h80000000, 31, 1'b0, 0, 1'b0);
    check("srl31 value", out_model, 32'h00000001);
    run_op("ignore", 32'h0000FF00, 8, 1'b0, 3, 1'b0);
    check("ignore value", out_model, 32'h000000FF);
    run_op("b2b first",  32'h0000FF00, 8, 1'b0, 0, 1'b1);
    run_op("b2b second", 32'hF0000000, 2, 1'b1, 0, 1'b0);
    check("b2b value", out_model, 32'hFC000000);

    // An asynchronous reset in the middle of a shift must clear everything at once.
    In    = 32'hDEADBEEF;
    Shamt = 5'd20;
    Arith = 1'b1;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid busy before rst", 32'(Busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst out",  Out, 32'h0);
    check("rst busy", 32'(Busy), 32'd0);
    check("rst done", 32'(Done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_model = 32'h0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      check("post rst no done", 32'(Done), 32'd0);
    end
    check("post rst out", Out, 32'h0);

    // Randomized operations, some chained back-to-back.
    for (int n = 0; n < 25; n++) begin
      run_op("rand", $urandom, int'($urandom_range(0, 31)), 1'($urandom), 0,
             1'($urandom_range(0, 1)));
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
